oc8051_cxrom_fetch: RTL and testbench

Registered fetch bridge between the oc8051 instruction Wishbone port and the fully-combinational code ROM. Latches the fetch address, drives it to the ROM, models programmable ROM wait states, and returns the 32-bit instruction word with a single-cycle ack. A one-entry line buffer answers repeated fetches of the same address without wait states. Saturating hit/miss counters support firmware profiling.

---
 rtl/oc8051_cxrom_fetch_pkg.sv | 16 +
 rtl/oc8051_sat_cnt.sv | 20 ++
 rtl/oc8051_cxrom_fetch.sv | 116 +++++++++++
 tb/tb_oc8051_cxrom_fetch.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oc8051_cxrom_fetch_pkg.sv
// Shared constants and state encoding for the oc8051 code-ROM fetch bridge.
package oc8051_cxrom_fetch_pkg;

  localparam int ROM_AW          = 16;
  localparam int ROM_DW          = 32;
  localparam int WAIT_STATES_DEF = 1;
  // Wait counter is sized for the legal wait-state range 0..15.
  localparam int WCNT_W          = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/oc8051_sat_cnt.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module oc8051_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count one per enabled cycle until all-ones is reached.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/oc8051_cxrom_fetch.sv
// Registered fetch bridge from the oc8051 instruction Wishbone port to a
// combinational code ROM, with programmable wait states, a one-entry line
// buffer and saturating hit/miss profiling counters.
//
//   state   | meaning
//   IDLE    | waiting for a request; hit check against the line buffer
//   WAIT    | miss in progress; counting down ROM wait states
//   ACK     | wbi_ack_o high for this single cycle
module oc8051_cxrom_fetch
  import oc8051_cxrom_fetch_pkg::*;
#(
  parameter int WAIT_STATES = WAIT_STATES_DEF,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROM_AW-1:0] wbi_adr_i,
  input  logic              wbi_stb_i,
  input  logic              wbi_cyc_i,
  output logic [ROM_DW-1:0] wbi_dat_o,
  output logic              wbi_ack_o,
  input  logic              flush,
  output logic [ROM_AW-1:0] cxrom_addr,
  input  logic [ROM_DW-1:0] cxrom_data_in,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  fetch_state_t      state;
  logic [WCNT_W-1:0] wait_cnt;
  logic              buf_valid;
  logic [ROM_AW-1:0] buf_tag;
  logic [ROM_DW-1:0] buf_data;

  logic req;
  logic hit;
  logic hit_inc;
  logic miss_inc;

  // Hit check uses the registered valid, so a coincident flush still serves the hit.
  always_comb begin
    req      = wbi_stb_i & wbi_cyc_i;
    hit      = buf_valid && (wbi_adr_i == buf_tag);
    hit_inc  = (state == ST_IDLE) && req && hit;
    miss_inc = (state == ST_WAIT) && req && (wait_cnt == '0);
  end

  // Fetch FSM, line buffer and ROM address register; flush overrides any valid set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      wbi_ack_o  <= 1'b0;
      wbi_dat_o  <= '0;
      cxrom_addr <= '0;
      wait_cnt   <= '0;
      buf_valid  <= 1'b0;
      buf_tag    <= '0;
      buf_data   <= '0;
    end else begin
      wbi_ack_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (hit) begin
              wbi_dat_o <= buf_data;
              wbi_ack_o <= 1'b1;
              state     <= ST_ACK;
            end else begin
              cxrom_addr <= wbi_adr_i;
              wait_cnt   <= WCNT_W'(WAIT_STATES);
              state      <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!req) begin
            state <= ST_IDLE;
          end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WCNT_W'(1);
          end else begin
            wbi_dat_o <= cxrom_data_in;
            buf_data  <= cxrom_data_in;
            buf_tag   <= cxrom_addr;
            buf_valid <= 1'b1;
            wbi_ack_o <= 1'b1;
            state     <= ST_ACK;
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
      if (flush) begin
        buf_valid <= 1'b0;
      end
    end
  end

  oc8051_sat_cnt #(.W(CNT_W)) u_hit_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit_inc),
    .cnt (hit_cnt)
  );

  oc8051_sat_cnt #(.W(CNT_W)) u_miss_cnt (
    .clk (clk),
    .rst (rst),
    .inc (miss_inc),
    .cnt (miss_cnt)
  );

endmodule

// File: tb/tb_oc8051_cxrom_fetch.sv
// Scoreboard bench for oc8051_cxrom_fetch: three instances with different
// wait-state / counter-width settings share clock, reset and flush.
module tb_oc8051_cxrom_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush;
  logic [15:0] adr    [3];
  logic        stb    [3];
  logic        cyc    [3];
  logic [31:0] dat_w  [3];
  logic        ack_w  [3];
  logic [15:0] ca_w   [3];
  logic [31:0] rom_w  [3];
  logic [15:0] hit0, hit1, miss0, miss1;
  logic [1:0]  hit2, miss2;

  int ncyc = 0;
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] rom(input logic [15:0] a);
    if (a == 16'h0000) return 32'h12345678;
    return {a ^ 16'hA5C3, a * 16'd7 + 16'h0001};
  endfunction

  assign rom_w[0] = rom(ca_w[0]);
  assign rom_w[1] = rom(ca_w[1]);
  assign rom_w[2] = rom(ca_w[2]);

  oc8051_cxrom_fetch #(.WAIT_STATES(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .wbi_adr_i(adr[0]), .wbi_stb_i(stb[0]), .wbi_cyc_i(cyc[0]),
    .wbi_dat_o(dat_w[0]), .wbi_ack_o(ack_w[0]), .flush(flush), .cxrom_addr(ca_w[0]),
    .cxrom_data_in(rom_w[0]), .hit_cnt(hit0), .miss_cnt(miss0));

  oc8051_cxrom_fetch #(.WAIT_STATES(3), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .wbi_adr_i(adr[1]), .wbi_stb_i(stb[1]), .wbi_cyc_i(cyc[1]),
    .wbi_dat_o(dat_w[1]), .wbi_ack_o(ack_w[1]), .flush(flush), .cxrom_addr(ca_w[1]),
    .cxrom_data_in(rom_w[1]), .hit_cnt(hit1), .miss_cnt(miss1));

  oc8051_cxrom_fetch #(.WAIT_STATES(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .wbi_adr_i(adr[2]), .wbi_stb_i(stb[2]), .wbi_cyc_i(cyc[2]),
    .wbi_dat_o(dat_w[2]), .wbi_ack_o(ack_w[2]), .flush(flush), .cxrom_addr(ca_w[2]),
    .cxrom_data_in(rom_w[2]), .hit_cnt(hit2), .miss_cnt(miss2));

  function automatic int get_hit(input int i);
    if (i == 0) return int'(hit0);
    if (i == 1) return int'(hit1);
    return int'(hit2);
  endfunction

  function automatic int get_miss(input int i);
    if (i == 0) return int'(miss0);
    if (i == 1) return int'(miss1);
    return int'(miss2);
  endfunction

  // Reference model: one buffered line per instance plus profiling counts.
  int          ws   [3] = '{1, 3, 0};
  int          cmax [3] = '{65535, 65535, 3};
  bit          m_valid [3];
  logic [15:0] m_tag   [3];
  logic [31:0] m_data  [3];
  int          m_hits  [3];
  int          m_miss  [3];

  typedef struct {
    int          inst;
    logic [31:0] dat;
    int          cyc;
    int          hits;
    int          misses;
  } exp_t;

  exp_t sb[$];

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_valid[k] = 1'b0; m_tag[k] = '0; m_data[k] = '0; m_hits[k] = 0; m_miss[k] = 0;
    end
  endfunction

  function automatic void chk(input string nm, input int i, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", nm, i, act, expv, ncyc);
    end
  endfunction

  always @(posedge clk) ncyc <= ncyc + 1;

  // Monitor: every ack pops the oldest expectation and compares.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        if (ack_w[i]) begin
          if (sb.size() == 0) begin
            chk("unexpected_ack", i, 1, 0);
          end else begin
            e = sb.pop_front();
            chk("ack_inst", i, i, e.inst);
            chk("ack_data", i, dat_w[i], e.dat);
            chk("ack_cycle", i, ncyc, e.cyc);
            chk("hit_cnt", i, get_hit(i), e.hits);
            chk("miss_cnt", i, get_miss(i), e.misses);
          end
        end
      end
    end
  end

  task automatic drive(input int i, input logic [15:0] a);
    for (int k = 0; k < 3; k++) begin
      stb[k] = 1'b0; cyc[k] = 1'b0;
    end
    adr[i] = a; stb[i] = 1'b1; cyc[i] = 1'b1;
  endtask

  task automatic idle(input int n, input bit fl);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      stb[k] = 1'b0; cyc[k] = 1'b0;
    end
    flush = fl;
    if (fl) for (int k = 0; k < 3; k++) m_valid[k] = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      flush = 1'b0;
    end
  endtask

  // One complete fetch; foff >= 0 pulses flush in cycle N+foff, chg scrambles
  // the address once the miss is latched.
  task automatic fetch(input int i, input logic [15:0] a, input int foff, input bit chg);
    bit   hit;
    int   lat;
    int   n;
    bit   done;
    exp_t e;
    @(posedge clk); #1;
    drive(i, a);
    flush = (foff == 0);
    n = ncyc;
    hit = m_valid[i] && (m_tag[i] == a);
    lat = hit ? 1 : 2 + ws[i];
    if (hit) begin
      m_hits[i] = (m_hits[i] < cmax[i]) ? m_hits[i] + 1 : cmax[i];
      e.dat = m_data[i];
    end else begin
      m_miss[i] = (m_miss[i] < cmax[i]) ? m_miss[i] + 1 : cmax[i];
      e.dat = rom(a);
      m_valid[i] = 1'b1; m_tag[i] = a; m_data[i] = rom(a);
    end
    e.inst = i; e.cyc = n + lat; e.hits = m_hits[i]; e.misses = m_miss[i];
    sb.push_back(e);
    if (foff >= 0) begin
      for (int k = 0; k < 3; k++) if (k != i) m_valid[k] = 1'b0;
      if (foff >= (hit ? 0 : lat - 1)) m_valid[i] = 1'b0;
    end
    done = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (ack_w[i]) begin
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        flush = (foff == t + 1);
        if (chg && !hit && t == 0) adr[i] = a ^ 16'h0100;
      end
    end
    if (!done) begin
      chk("ack_timeout", i, 0, 1);
      if (sb.size() != 0) void'(sb.pop_back());
    end
  endtask

  // Miss withdrawn in cycle N+j (1..1+WAIT_STATES): no ack, no state change.
  task automatic abort_fetch(input int i, input logic [15:0] a, input int j, input bit drop_cyc);
    @(posedge clk); #1;
    drive(i, a);
    flush = 1'b0;
    repeat (j) @(posedge clk);
    #1;
    if (drop_cyc) cyc[i] = 1'b0; else stb[i] = 1'b0;
    repeat (ws[i] + 3) @(posedge clk);
    #1;
    stb[i] = 1'b0; cyc[i] = 1'b0;
    chk("abort_hit_cnt", i, get_hit(i), m_hits[i]);
    chk("abort_miss_cnt", i, get_miss(i), m_miss[i]);
  endtask

  task automatic reset_mid(input int i, input logic [15:0] a, input int k);
    @(posedge clk); #1;
    drive(i, a);
    flush = 1'b0;
    repeat (k) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_dat", d, dat_w[d], 0);
      chk("rst_ack", d, ack_w[d], 0);
      chk("rst_addr", d, ca_w[d], 0);
      chk("rst_hit", d, get_hit(d), 0);
      chk("rst_miss", d, get_miss(d), 0);
    end
    @(posedge clk); #1;
    stb[i] = 1'b0; cyc[i] = 1'b0;
    rst = 1'b1;
    model_reset();
  endtask

  logic [15:0] addrs [5] = '{16'h0000, 16'h0004, 16'h0008, 16'h0010, 16'h0014};

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      adr[k] = '0; stb[k] = 1'b0; cyc[k] = 1'b0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_dat", d, dat_w[d], 0);
      chk("reset_ack", d, ack_w[d], 0);
      chk("reset_addr", d, ca_w[d], 0);
      chk("reset_hit", d, get_hit(d), 0);
      chk("reset_miss", d, get_miss(d), 0);
    end
    rst = 1'b1;

    // Miss, immediate refetch hit, then a new miss.
    fetch(0, 16'h0000, -1, 1'b0);
    fetch(0, 16'h0000, -1, 1'b0);
    fetch(0, 16'h0004, -1, 1'b0);
    idle(2, 1'b0);

    // Withdrawn miss leaves the old line intact.
    fetch(1, 16'h0020, -1, 1'b0);
    idle(1, 1'b0);
    abort_fetch(1, 16'h0040, 2, 1'b0);
    fetch(1, 16'h0020, -1, 1'b0);
    idle(1, 1'b0);

    // Flush coinciding with the capture: data returned, line invalid.
    fetch(1, 16'h0010, 4, 1'b0);
    fetch(1, 16'h0010, -1, 1'b0);
    idle(1, 1'b0);

    // Zero wait states, 2-bit counters saturating.
    fetch(2, 16'h0008, -1, 1'b0);
    for (int r = 0; r < 5; r++) fetch(2, 16'h0008, -1, 1'b0);
    idle(1, 1'b0);

    // Randomized traffic across all instances.
    for (int it = 0; it < 80; it++) begin
      int          i;
      logic [15:0] a;
      bit          hit;
      int          r;
      int          lat;
      i = $urandom_range(0, 2);
      a = addrs[$urandom_range(0, 4)];
      hit = m_valid[i] && (m_tag[i] == a);
      lat = hit ? 1 : 2 + ws[i];
      r = $urandom_range(0, 9);
      if (r < 2 && !hit) begin
        abort_fetch(i, a, $urandom_range(1, 1 + ws[i]), 1'($urandom_range(0, 1)));
      end else if (r < 4) begin
        fetch(i, a, $urandom_range(0, lat), 1'b0);
      end else begin
        fetch(i, a, -1, (!hit) && ($urandom_range(0, 3) == 0));
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3), ($urandom_range(0, 4) == 0));
    end

    // Reset during WAIT, then the same address must miss.
    idle(1, 1'b0);
    reset_mid(1, 16'h0030, 2);
    fetch(1, 16'h0030, -1, 1'b0);
    fetch(1, 16'h0030, -1, 1'b0);
    idle(3, 1'b0);

    chk("sb_drain", 0, sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
